uart_frame_tx: RTL and testbench

Parametrised multi-byte UART transmitter. It latches a word of NUM_BYTES characters on a start pulse and serialises them back-to-back on `tx` at a baud rate derived from the system clock. Each character uses 8N1-style framing with configurable data bits, stop bits and inter-byte gap. It supersedes the fixed 16-bit transmitter in the LED-matrix/UART top level and drives the same `tx` pin, with per-byte and end-of-frame status.

---
 rtl/uart_pkg.sv | 42 ++++
 rtl/uart_baud_tick.sv | 37 +++
 rtl/uart_frame_tx.sv | 166 ++++++++++++++++
 tb/tb_uart_frame_tx.sv | 227 ++++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// Shared types and elaboration helpers for the UART transmit/receive blocks.
// UART_PARITY_EN adds the PARITY state to the transmitter state set.
package uart_pkg;

  // Transmitter state set; PARITY exists only when parity is compiled in.
  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_START  = 3'd1,
    ST_DATA   = 3'd2,
`ifdef UART_PARITY_EN
    ST_PARITY = 3'd3,
`endif
    ST_STOP   = 3'd4,
    ST_GAP    = 3'd5
  } uart_tx_state_t;

  // Widest supported character.
  localparam int unsigned MAX_DATA_BITS = 8;

  // Clock cycles per bit-time.
  function automatic int unsigned div_calc(input int unsigned clk_hz,
                                           input int unsigned baud);
    return clk_hz / baud;
  endfunction

  // Width of the character index, never below one bit.
  function automatic int unsigned idx_width(input int unsigned num_bytes);
    return (num_bytes > 1) ? $clog2(num_bytes) : 1;
  endfunction

  // Width of a counter that spans 0..div-1, never below one bit.
  function automatic int unsigned cnt_width(input int unsigned div);
    return (div > 1) ? $clog2(div) : 1;
  endfunction

  // Parity over a character (zero-extended to 8 bits); odd=1 inverts the sense.
  function automatic logic parity_calc(input logic [MAX_DATA_BITS-1:0] data,
                                       input logic odd);
    return (^data) ^ odd;
  endfunction

endpackage

// File: rtl/uart_baud_tick.sv
// Bit-time timer: restarts on load, advances while enabled and flags the
// last cycle of every DIV-cycle bit-time. Shared with the receiver side.
module uart_baud_tick
  import uart_pkg::*;
#(
  parameter int unsigned DIV = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic load,
  input  logic en,
  output logic tick_c
);

  localparam int unsigned CNT_W = cnt_width(DIV);

  logic [CNT_W-1:0] cnt;

  // Tick on the final cycle of the bit-time so the consumer moves on at its end.
  assign tick_c = en && (cnt == CNT_W'(DIV - 1));

  // Cycle counter, wrapping every DIV enabled cycles.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt <= '0;
    end else if (load) begin
      cnt <= '0;
    end else if (en) begin
      if (cnt == CNT_W'(DIV - 1)) begin
        cnt <= '0;
      end else begin
        cnt <= cnt + CNT_W'(1);
      end
    end
  end

endmodule

// File: rtl/uart_frame_tx.sv
// Multi-byte UART transmitter: latches NUM_BYTES characters on start and sends
// them back-to-back with start/data/stop framing and optional inter-byte gap.
// Define UART_PARITY_EN to insert one parity bit after the data bits.
module uart_frame_tx
  import uart_pkg::*;
#(
  parameter int unsigned CLK_HZ     = 50_000_000,
  parameter int unsigned BAUD       = 115200,
  parameter int unsigned DATA_BITS  = 8,
  parameter int unsigned NUM_BYTES  = 2,
  parameter int unsigned STOP_BITS  = 1,
  parameter int unsigned GAP_BITS   = 0,
  parameter int unsigned PARITY_ODD = 0
) (
  input  logic                               clk,
  input  logic                               rst,
  input  logic                               start,
  input  logic [NUM_BYTES*DATA_BITS-1:0]     data_in,
  output logic                               tx,
  output logic                               busy,
  output logic [idx_width(NUM_BYTES)-1:0]    byte_idx,
  output logic                               byte_done,
  output logic                               frame_done
);

  localparam int unsigned DIV     = div_calc(CLK_HZ, BAUD);
  localparam int unsigned IDX_W   = idx_width(NUM_BYTES);
  localparam int unsigned BIT_W   = $clog2(DATA_BITS);
  localparam int unsigned FRAME_W = NUM_BYTES * DATA_BITS;
  localparam int unsigned REP_W   = 4;

  uart_tx_state_t     state;
  logic [FRAME_W-1:0] shreg;
  logic [BIT_W-1:0]   bit_cnt;
  logic [REP_W-1:0]   rep_cnt;
  logic               tick_c;
  logic               baud_load_c;
  logic               baud_en_c;
`ifdef UART_PARITY_EN
  logic               par_bit;
`endif

  // Bit timer is held at zero in IDLE and wraps at every bit boundary.
  assign baud_load_c = (state == ST_IDLE);
  assign baud_en_c   = (state != ST_IDLE);

  uart_baud_tick #(
    .DIV (DIV)
  ) u_baud_tick (
    .clk    (clk),
    .rst    (rst),
    .load   (baud_load_c),
    .en     (baud_en_c),
    .tick_c (tick_c)
  );

  // Frame sequencer; tx and status are registered alongside the state.
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= ST_IDLE;
      shreg      <= '0;
      bit_cnt    <= '0;
      rep_cnt    <= '0;
      tx         <= 1'b1;
      busy       <= 1'b0;
      byte_idx   <= '0;
      byte_done  <= 1'b0;
      frame_done <= 1'b0;
`ifdef UART_PARITY_EN
      par_bit    <= 1'b0;
`endif
    end else begin
      byte_done  <= 1'b0;
      frame_done <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (start) begin
            shreg    <= data_in;
            byte_idx <= '0;
            tx       <= 1'b0;
            busy     <= 1'b1;
            state    <= ST_START;
          end
        end
        ST_START: begin
          if (tick_c) begin
            bit_cnt <= '0;
            tx      <= shreg[0];
            state   <= ST_DATA;
`ifdef UART_PARITY_EN
            par_bit <= parity_calc(MAX_DATA_BITS'(shreg[DATA_BITS-1:0]), 1'(PARITY_ODD));
`endif
          end
        end
        ST_DATA: begin
          if (tick_c) begin
            shreg <= shreg >> 1;
            if (bit_cnt == BIT_W'(DATA_BITS - 1)) begin
`ifdef UART_PARITY_EN
              tx    <= par_bit;
              state <= ST_PARITY;
`else
              tx      <= 1'b1;
              rep_cnt <= '0;
              state   <= ST_STOP;
`endif
            end else begin
              bit_cnt <= bit_cnt + BIT_W'(1);
              tx      <= shreg[1];
            end
          end
        end
`ifdef UART_PARITY_EN
        ST_PARITY: begin
          if (tick_c) begin
            tx      <= 1'b1;
            rep_cnt <= '0;
            state   <= ST_STOP;
          end
        end
`endif
        ST_STOP: begin
          if (tick_c) begin
            if (rep_cnt == REP_W'(STOP_BITS - 1)) begin
              byte_done <= 1'b1;
              rep_cnt   <= '0;
              if (byte_idx == IDX_W'(NUM_BYTES - 1)) begin
                frame_done <= 1'b1;
                busy       <= 1'b0;
                tx         <= 1'b1;
                state      <= ST_IDLE;
              end else begin
                byte_idx <= byte_idx + IDX_W'(1);
                if (GAP_BITS > 0) begin
                  tx    <= 1'b1;
                  state <= ST_GAP;
                end else begin
                  tx    <= 1'b0;
                  state <= ST_START;
                end
              end
            end else begin
              rep_cnt <= rep_cnt + REP_W'(1);
            end
          end
        end
        ST_GAP: begin
          if (tick_c) begin
            if (rep_cnt == REP_W'(GAP_BITS - 1)) begin
              tx    <= 1'b0;
              state <= ST_START;
            end else begin
              rep_cnt <= rep_cnt + REP_W'(1);
            end
          end
        end
        default: begin
          tx    <= 1'b1;
          busy  <= 1'b0;
          state <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_uart_frame_tx.sv
// Scoreboard bench for uart_frame_tx: two configurations share one stimulus
// stream; a line-level reference model predicts every output cycle.
module tb_uart_frame_tx;

  localparam int unsigned CLK_HZ = 1000;
  localparam int unsigned BAUD   = 100;
  localparam int unsigned DIV    = CLK_HZ / BAUD;

  localparam int unsigned NB0 = 2, DB0 = 8, SB0 = 1, GB0 = 0, PO0 = 0;
  localparam int unsigned NB1 = 3, DB1 = 7, SB1 = 2, GB1 = 2, PO1 = 1;
`ifdef UART_PARITY_EN
  localparam int PAR = 1;
`else
  localparam int PAR = 0;
`endif

  logic clk = 1'b0;
  logic rst;
  logic start;
  logic [NB0*DB0-1:0] d0;
  logic [NB1*DB1-1:0] d1;
  logic       tx0, busy0, bd0, fd0;
  logic [0:0] idx0;
  logic       tx1, busy1, bd1, fd1;
  logic [1:0] idx1;

  always #5 clk = ~clk;

  uart_frame_tx #(
    .CLK_HZ(CLK_HZ), .BAUD(BAUD), .DATA_BITS(DB0), .NUM_BYTES(NB0),
    .STOP_BITS(SB0), .GAP_BITS(GB0), .PARITY_ODD(PO0)
  ) dut0 (
    .clk(clk), .rst(rst), .start(start), .data_in(d0), .tx(tx0), .busy(busy0),
    .byte_idx(idx0), .byte_done(bd0), .frame_done(fd0)
  );

  uart_frame_tx #(
    .CLK_HZ(CLK_HZ), .BAUD(BAUD), .DATA_BITS(DB1), .NUM_BYTES(NB1),
    .STOP_BITS(SB1), .GAP_BITS(GB1), .PARITY_ODD(PO1)
  ) dut1 (
    .clk(clk), .rst(rst), .start(start), .data_in(d1), .tx(tx1), .busy(busy1),
    .byte_idx(idx1), .byte_done(bd1), .frame_done(fd1)
  );

  // One expected output cycle.
  typedef struct {
    int tx;
    int busy;
    int bd;
    int fd;
    int idx;
  } exp_t;

  exp_t q0[$];
  exp_t q1[$];
  int   idle_idx0 = 0;
  int   idle_idx1 = 0;
  int   n_checks  = 0;
  int   n_fail    = 0;
  bit   mon_en    = 1'b0;
  exp_t e0, e1;

  task automatic chk(input string nm, input int act, input int expv);
    n_checks++;
    if (act != expv) begin
      n_fail++;
      if (n_fail <= 40)
        $display("FAIL %s: got %0d, expected %0d at t=%0t", nm, act, expv, $time);
    end
  endtask

  task automatic push_e(input int id, input int txv, input int bsy, input int bdv,
                        input int fdv, input int idxv);
    exp_t e;
    e.tx = txv; e.busy = bsy; e.bd = bdv; e.fd = fdv; e.idx = idxv;
    if (id == 0) q0.push_back(e);
    else         q1.push_back(e);
  endtask

  // Line-level model: list each character's bits, stretch each to DIV cycles.
  task automatic model_frame(input int id, input int nb, input int db, input int sb,
                             input int gb, input int po, input logic [31:0] data);
    int bits[$];
    int ch;
    int pend;
    pend = 0;
    for (int k = 0; k < nb; k++) begin
      ch = int'((data >> (k * db)) & ((32'd1 << db) - 32'd1));
      bits = {};
      bits.push_back(0);
      for (int b = 0; b < db; b++) bits.push_back((ch >> b) & 1);
      if (PAR == 1) bits.push_back(($countones(ch) + po) % 2);
      for (int s = 0; s < sb; s++) bits.push_back(1);
      foreach (bits[i]) begin
        for (int c = 0; c < int'(DIV); c++) begin
          push_e(id, bits[i], 1, pend, 0, k);
          pend = 0;
        end
      end
      pend = 1;
      if (k < nb - 1) begin
        for (int c = 0; c < gb * int'(DIV); c++) begin
          push_e(id, 1, 1, pend, 0, k + 1);
          pend = 0;
        end
      end
    end
    push_e(id, 1, 0, 1, 1, nb - 1);
    if (id == 0) idle_idx0 = nb - 1;
    else         idle_idx1 = nb - 1;
  endtask

  // Applied at each rising edge with the inputs the DUTs sample there.
  task automatic model_edge();
    if (rst) begin
      q0.delete();
      q1.delete();
      idle_idx0 = 0;
      idle_idx1 = 0;
    end else if (start) begin
      if (q0.size() == 0) model_frame(0, NB0, DB0, SB0, GB0, PO0, 32'(d0));
      if (q1.size() == 0) model_frame(1, NB1, DB1, SB1, GB1, PO1, 32'(d1));
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    model_edge();
    #1;
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    while ((q0.size() != 0 || q1.size() != 0) && n < 2000) begin
      cyc();
      n++;
    end
    chk("idle_timeout", n < 2000 ? 1 : 0, 1);
  endtask

  // Monitor: pop the prediction for this cycle, or expect the idle line.
  always @(negedge clk) begin
    if (mon_en) begin
      if (q0.size() > 0) e0 = q0.pop_front();
      else begin e0.tx = 1; e0.busy = 0; e0.bd = 0; e0.fd = 0; e0.idx = idle_idx0; end
      if (q1.size() > 0) e1 = q1.pop_front();
      else begin e1.tx = 1; e1.busy = 0; e1.bd = 0; e1.fd = 0; e1.idx = idle_idx1; end
      chk("d0_tx",         int'(tx0),   e0.tx);
      chk("d0_busy",       int'(busy0), e0.busy);
      chk("d0_byte_done",  int'(bd0),   e0.bd);
      chk("d0_frame_done", int'(fd0),   e0.fd);
      chk("d0_byte_idx",   int'(idx0),  e0.idx);
      chk("d1_tx",         int'(tx1),   e1.tx);
      chk("d1_busy",       int'(busy1), e1.busy);
      chk("d1_byte_done",  int'(bd1),   e1.bd);
      chk("d1_frame_done", int'(fd1),   e1.fd);
      chk("d1_byte_idx",   int'(idx1),  e1.idx);
    end
  end

  initial begin
    rst = 1'b1; start = 1'b0; d0 = '0; d1 = '0;
    cyc();
    mon_en = 1'b1;
    cyc(); cyc();
    rst = 1'b0;
    repeat (3) cyc();

    // Reference frame, with an ignored re-pulse carrying different data.
    d0 = 16'hC281; d1 = 21'h0C281; start = 1'b1;
    cyc();
    start = 1'b0;
    repeat (49) cyc();
    d0 = 16'hFFFF; d1 = '1; start = 1'b1;
    cyc();
    start = 1'b0;
    wait_idle();
    repeat (4) cyc();

    // Reset mid-frame, then a clean frame.
    d0 = 16'h5AA5; d1 = 21'h12345; start = 1'b1;
    cyc();
    start = 1'b0;
    repeat (34) cyc();
    rst = 1'b1;
    cyc();
    rst = 1'b0;
    repeat (5) cyc();
    d0 = 16'h3C0F; d1 = 21'h1ABCD; start = 1'b1;
    cyc();
    start = 1'b0;
    wait_idle();

    // start held high: back-to-back frames, new data every cycle.
    start = 1'b1;
    for (int i = 0; i < 900; i++) begin
      d0 = 16'($urandom); d1 = 21'($urandom);
      cyc();
    end
    start = 1'b0;
    wait_idle();

    // Random pulses, random data, occasional reset.
    for (int i = 0; i < 2500; i++) begin
      start = ($urandom_range(0, 15) == 0);
      rst   = ($urandom_range(0, 499) == 0);
      d0 = 16'($urandom); d1 = 21'($urandom);
      cyc();
    end
    start = 1'b0; rst = 1'b0;
    wait_idle();
    repeat (3) cyc();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not complete, expected finish before %0t", $time);
    n_fail++;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
